// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus port of the memory-mapped UART transmitter.
// Loads are answered combinationally on rdata.
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, we, re, addr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, we, re, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, serializer,
// status/config registers and a level interrupt.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic            clk,
  input  logic            rst,
  mmio_uart_tx_if.slave   bus,
  output logic            tx,
  output logic            irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [15:0]   div_q;
  logic          tx_en_q, irq_en_q;
  logic          irq_q;

  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   eff_q, eff_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic [1:0]    idx;
  logic          wr;
  logic          full, empty, busy;
  logic          push_req, push, pop;
  logic          bit_end;
  logic          unused_ok;

  assign idx      = bus.addr[3:2];
  assign wr       = bus.sel & bus.we;
  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign busy     = state_q != IDLE;
  assign push_req = wr & (idx == 2'd0);
  assign push     = push_req & ~full;
  assign bit_end  = timer_q == eff_q - 16'd1;
  assign irq      = irq_q;

  assign unused_ok = ^{bus.addr[1:0], bus.wdata[31:16]};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    eff_d   = eff_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[tail_q];
          eff_d   = (div_q == '0) ? 16'd1 : div_q;
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Line level decoded from state so reset forces idle-high immediately.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[head_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= IDLE;
      timer_q  <= '0;
      eff_q    <= 16'd1;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      timer_q <= timer_d;
      eff_q   <= eff_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      irq_q   <= irq_en_q & empty & ~busy;
      if (push) head_q <= head_q + AW'(1);
      if (pop)  tail_q <= tail_q + AW'(1);
      if (push_req && full)
        ovf_q <= 1'b1;
      else if (wr && idx == 2'd1 && bus.wdata[3])
        ovf_q <= 1'b0;
      if (wr && idx == 2'd2) div_q <= bus.wdata[15:0];
      if (wr && idx == 2'd3) begin
        tx_en_q  <= bus.wdata[0];
        irq_en_q <= bus.wdata[1];
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel && bus.re) begin
      unique case (idx)
        2'd1: bus.rdata = {16'b0, {(8-CW){1'b0}}, count_q,
                           4'b0, ovf_q, busy, empty, full};
        2'd2: bus.rdata = {16'b0, div_q};
        2'd3: bus.rdata = {30'b0, irq_en_q, tx_en_q};
        default: bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing,
// FIFO overflow, back-to-back timing, irq and async reset.
module tb_mmio_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, irq;
  int   checks = 0;
  int   errors = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [1:0] idx, input logic [31:0] d);
    @(negedge clk);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = {idx, 2'b00};
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.re   = 1'b1;
    bus.addr = {idx, 2'b00};
    #1;
    d = bus.rdata;
    bus.sel = 1'b0;
    bus.re  = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples one frame starting at the current cycle; sym[k] is the
  // level of symbol k, steady drops if a symbol wobbles or busy falls.
  task automatic rx_frame(input int div, input bit chk_busy,
                          output logic [9:0] sym, output bit steady);
    logic [31:0] d;
    steady = 1'b1;
    sym    = '0;
    for (int i = 0; i < 10 * div; i++) begin
      if (i > 0) @(negedge clk);
      if (i % div == 0) sym[i/div] = tx;
      else if (tx !== sym[i/div]) steady = 1'b0;
      if (chk_busy) begin
        rd(2'd1, d);
        if (d[2] !== 1'b1) steady = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus.sel = 0; bus.we = 0; bus.re = 0;
    bus.addr = '0; bus.wdata = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_lines tx=%b irq=%b want 1 0", tx, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL reset_status got %h want 00000002", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd868) begin
      errors++;
      $display("FAIL reset_baud got %0d want 868", d);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL reset_ctrl got %h want 1", d);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read got %h want 0", d);
    end
  endtask

  task automatic test_frame;
    logic [31:0] d;
    logic [9:0]  sym;
    bit          st;
    bus_wr(2'd2, 32'd4);
    bus_wr(2'd0, 32'hA5);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h100 || tx !== 1'b1) begin
      errors++;
      $display("FAIL push_latency status=%h tx=%b want 00000100 1", d, tx);
    end
    @(negedge clk);
    rx_frame(4, 1'b1, sym, st);
    checks++;
    if (sym !== {1'b1, 8'hA5, 1'b0} || !st) begin
      errors++;
      $display("FAIL frame_a5 sym=%b steady=%b want %b 1",
               sym, st, {1'b1, 8'hA5, 1'b0});
    end
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2 || tx !== 1'b1) begin
      errors++;
      $display("FAIL frame_len status=%h tx=%b want 00000002 1", d, tx);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic [9:0]  sym;
    bit          st, ok;
    bus_wr(2'd2, 32'd1);
    bus_wr(2'd3, 32'd0);
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'(i));
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h809) begin
      errors++;
      $display("FAIL full_status got %h want 00000809", d);
    end
    bus_wr(2'd3, 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_start(ok);
      rx_frame(1, 1'b0, sym, st);
      checks++;
      if (!ok || sym !== {1'b1, 8'(k), 1'b0} || !st) begin
        errors++;
        $display("FAIL drain_%0d sym=%b ok=%b want %b",
                 k, sym, ok, {1'b1, 8'(k), 1'b0});
      end
    end
    @(negedge clk);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'hA || tx !== 1'b1) begin
      errors++;
      $display("FAIL drained_status got %h tx=%b want 0000000a 1", d, tx);
    end
    bus_wr(2'd1, 32'h8);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ovf_clear got %h want 00000002", d);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] d;
    logic [9:0]  sym;
    bit          st, ok;
    bus_wr(2'd2, 32'hFFFF_0000);
    @(negedge clk);
    rd(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL baud_zero_rd got %h want 0", d);
    end
    bus_wr(2'd0, 32'h3C);
    wait_start(ok);
    rx_frame(1, 1'b1, sym, st);
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (!ok || sym !== {1'b1, 8'h3C, 1'b0} || !st || d !== 32'h2) begin
      errors++;
      $display("FAIL div0_frame sym=%b status=%h want %b 00000002",
               sym, d, {1'b1, 8'h3C, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [9:0]  s1, s2;
    bit          st1, st2;
    logic        hi0, hi1, lo;
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h55);
    bus_wr(2'd0, 32'hC3);
    @(negedge clk);
    fork
      rx_frame(2, 1'b0, s1, st1);
      bus_wr(2'd2, 32'd3);
    join
    checks++;
    if (s1 !== {1'b1, 8'h55, 1'b0} || !st1) begin
      errors++;
      $display("FAIL b2b_frame1 sym=%b steady=%b want %b 1",
               s1, st1, {1'b1, 8'h55, 1'b0});
    end
    @(negedge clk);
    hi0 = tx;
    @(negedge clk);
    lo = tx;
    hi1 = 1'b1;
    checks++;
    if (hi0 !== 1'b1 || lo !== 1'b0 || hi1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap idle=%b next=%b want 1 0", hi0, lo);
    end
    rx_frame(3, 1'b0, s2, st2);
    checks++;
    if (s2 !== {1'b1, 8'hC3, 1'b0} || !st2) begin
      errors++;
      $display("FAIL b2b_frame2 sym=%b steady=%b want %b 1",
               s2, st2, {1'b1, 8'hC3, 1'b0});
    end
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL b2b_end status=%h want 00000002", d);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bit          seen_hi, done;
    bus_wr(2'd3, 32'd3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_idle got %b want 1", irq);
    end
    bus_wr(2'd0, 32'h81);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold got %b want 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop got %b want 0", irq);
    end
    seen_hi = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rd(2'd1, d);
      if (irq !== 1'b0) seen_hi = 1'b1;
      if (d[2] === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || seen_hi) begin
      errors++;
      $display("FAIL irq_busy done=%b irq_seen=%b want 1 0", done, seen_hi);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise got %b want 1", irq);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bit          ok;
    bus_wr(2'd0, 32'h00);
    wait_start(ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || tx !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_data tx=%b ok=%b want 0 1", tx, ok);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset tx=%b irq=%b want 1 0", tx, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL post_rst_status got %h want 00000002", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd868) begin
      errors++;
      $display("FAIL post_rst_baud got %0d want 868", d);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL post_rst_ctrl got %h want 1", d);
    end
    bus.sel  = 1'b0;
    bus.re   = 1'b1;
    bus.addr = 4'h8;
    #1;
    checks++;
    if (bus.rdata !== 32'h0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL nosel_read rdata=%h tx=%b want 0 1", bus.rdata, tx);
    end
    bus.re = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_irq();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
